// File: rtl/ecc_20_scrub_ctrl.sv
// Background ECC scrubber: walks the protected RAM, checks each word through the
// duplicated checker, writes back single-bit corrections and tallies uncorrectable events.
module ecc_20_scrub_ctrl #(
    parameter int DATA_WIDTH   = 20,
    parameter int PARITY_WIDTH = 6,
    parameter int ADDR_WIDTH   = 5,
    parameter int DEPTH        = 32,
    parameter int RD_LAT       = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 scrub_en,
    input  logic [15:0]                          scrub_interval,
    input  logic                                 fifo_busy,
    output logic                                 ram_rd_en,
    output logic [ADDR_WIDTH-1:0]                ram_rd_addr,
    input  logic [DATA_WIDTH+PARITY_WIDTH-1:0]   ram_rd_data,
    output logic                                 ram_wr_en,
    output logic [ADDR_WIDTH-1:0]                ram_wr_addr,
    output logic [DATA_WIDTH+PARITY_WIDTH-1:0]   ram_wr_data,
    output logic [DATA_WIDTH-1:0]                chk_data,
    output logic [PARITY_WIDTH-1:0]              chk_parity,
    output logic                                 chk_fault_detc_en,
    input  logic [DATA_WIDTH-1:0]                chk_data_out,
    input  logic                                 chk_ecc_fault,
    input  logic                                 chk_sbit_err,
    input  logic                                 chk_dbit_err,
    output logic [DATA_WIDTH-1:0]                enc_data,
    input  logic [PARITY_WIDTH-1:0]              enc_parity,
    output logic                                 busy,
    output logic                                 pass_done,
    output logic [CNT_WIDTH-1:0]                 sbit_cnt,
    output logic [CNT_WIDTH-1:0]                 dbit_cnt,
    output logic [CNT_WIDTH-1:0]                 fault_cnt,
    output logic [ADDR_WIDTH-1:0]                dbit_addr,
    output logic                                 err_pulse
);

    localparam int CNT_SBIT  = 0;
    localparam int CNT_DBIT  = 1;
    localparam int CNT_FAULT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_CHK,
        S_WB,
        S_NEXT,
        S_WAIT
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_next;
    logic [2:0]              lat_reg, lat_next;
    logic [15:0]             ivl_reg, ivl_next;
    logic                    busy_seen_reg, busy_seen_next;
    logic [DATA_WIDTH-1:0]   wb_data_reg, wb_data_next;
    logic [ADDR_WIDTH-1:0]   dbit_addr_reg, dbit_addr_next;
    logic                    fdet_reg;
    logic [2:0]              cnt_inc;
    logic [CNT_WIDTH-1:0]    cnt_val [3];
    logic                    rd_en_c, wr_en_c, pass_done_c, err_c;
    logic                    last_addr;

    assign last_addr = (ptr_reg == ADDR_WIDTH'(DEPTH - 1));

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        lat_next       = lat_reg;
        ivl_next       = ivl_reg;
        busy_seen_next = busy_seen_reg;
        wb_data_next   = wb_data_reg;
        dbit_addr_next = dbit_addr_reg;
        cnt_inc        = 3'b000;
        rd_en_c        = 1'b0;
        wr_en_c        = 1'b0;
        pass_done_c    = 1'b0;
        err_c          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (scrub_en) begin
                    state_next = S_RD;
                end
            end
            S_RD: begin
                // The functional port owns the RAM whenever it is busy.
                if (!fifo_busy) begin
                    rd_en_c        = 1'b1;
                    busy_seen_next = 1'b0;
                    lat_next       = 3'(RD_LAT - 1);
                    state_next     = (RD_LAT == 1) ? S_CHK : S_LAT;
                end
            end
            S_LAT: begin
                if (fifo_busy) begin
                    busy_seen_next = 1'b1;
                end
                if (lat_reg <= 3'd1) begin
                    state_next = S_CHK;
                end else begin
                    lat_next = lat_reg - 3'd1;
                end
            end
            S_CHK: begin
                if (fifo_busy) begin
                    busy_seen_next = 1'b1;
                end
                if (chk_ecc_fault) begin
                    cnt_inc[CNT_FAULT] = 1'b1;
                    err_c              = 1'b1;
                    state_next         = S_NEXT;
                end else if (chk_dbit_err) begin
                    cnt_inc[CNT_DBIT] = 1'b1;
                    dbit_addr_next    = ptr_reg;
                    err_c             = 1'b1;
                    state_next        = S_NEXT;
                end else if (chk_sbit_err) begin
                    wb_data_next = chk_data_out;
                    state_next   = S_WB;
                end else begin
                    state_next = S_NEXT;
                end
            end
            S_WB: begin
                // Any functional access since the read may have changed the word: re-read it.
                if (busy_seen_reg || fifo_busy) begin
                    busy_seen_next = 1'b1;
                    state_next     = S_RD;
                end else begin
                    wr_en_c           = 1'b1;
                    cnt_inc[CNT_SBIT] = 1'b1;
                    state_next        = S_NEXT;
                end
            end
            S_NEXT: begin
                pass_done_c = last_addr;
                ptr_next    = last_addr ? '0 : ptr_reg + 1'b1;
                ivl_next    = scrub_interval;
                if (!scrub_en) begin
                    ptr_next   = '0;
                    state_next = S_IDLE;
                end else if (scrub_interval == 16'd0) begin
                    state_next = S_RD;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!scrub_en) begin
                    ptr_next   = '0;
                    state_next = S_IDLE;
                end else if (ivl_reg <= 16'd1) begin
                    state_next = S_RD;
                end else begin
                    ivl_next = ivl_reg - 16'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            lat_reg       <= '0;
            ivl_reg       <= '0;
            busy_seen_reg <= 1'b0;
            wb_data_reg   <= '0;
            dbit_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            lat_reg       <= lat_next;
            ivl_reg       <= ivl_next;
            busy_seen_reg <= busy_seen_next;
            wb_data_reg   <= wb_data_next;
            dbit_addr_reg <= dbit_addr_next;
        end
    end

    always_ff @(posedge clk) begin
        fdet_reg <= 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    // Strobes are masked by rst so a reset landing in WB never commits the write.
    assign ram_rd_en         = rd_en_c & ~rst;
    assign ram_wr_en         = wr_en_c & ~rst;
    assign pass_done         = pass_done_c & ~rst;
    assign err_pulse         = err_c & ~rst;
    assign ram_rd_addr       = ptr_reg;
    assign ram_wr_addr       = ptr_reg;
    assign ram_wr_data       = {enc_parity, wb_data_reg};
    assign chk_data          = ram_rd_data[DATA_WIDTH-1:0];
    assign chk_parity        = ram_rd_data[DATA_WIDTH+PARITY_WIDTH-1:DATA_WIDTH];
    assign chk_fault_detc_en = fdet_reg;
    assign enc_data          = wb_data_reg;
    assign busy              = (state_reg != S_IDLE);
    assign sbit_cnt          = cnt_val[CNT_SBIT];
    assign dbit_cnt          = cnt_val[CNT_DBIT];
    assign fault_cnt         = cnt_val[CNT_FAULT];
    assign dbit_addr         = dbit_addr_reg;

endmodule

// File: tb/tb_ecc_20_scrub_ctrl.sv
// Scoreboard bench for the ECC scrubber: a RAM model with error injection and a
// table-driven checker model; expected write-backs and error events are queued up front.
module tb_ecc_20_scrub_ctrl;

    localparam int DW = 20;
    localparam int PW = 6;
    localparam int AW = 5;
    localparam int DEPTH = 32;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            scrub_en = 1'b0;
    logic [15:0]     scrub_interval = 16'd0;
    logic            fifo_busy = 1'b0;
    logic            ram_rd_en;
    logic [AW-1:0]   ram_rd_addr;
    logic [DW+PW-1:0] ram_rd_data;
    logic            ram_wr_en;
    logic [AW-1:0]   ram_wr_addr;
    logic [DW+PW-1:0] ram_wr_data;
    logic [DW-1:0]   chk_data;
    logic [PW-1:0]   chk_parity;
    logic            chk_fault_detc_en;
    logic [DW-1:0]   chk_data_out;
    logic            chk_ecc_fault;
    logic            chk_sbit_err;
    logic            chk_dbit_err;
    logic [DW-1:0]   enc_data;
    logic [PW-1:0]   enc_parity;
    logic            busy;
    logic            pass_done;
    logic [CW-1:0]   sbit_cnt;
    logic [CW-1:0]   dbit_cnt;
    logic [CW-1:0]   fault_cnt;
    logic [AW-1:0]   dbit_addr;
    logic            err_pulse;

    ecc_20_scrub_ctrl dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
        .fifo_busy(fifo_busy), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .chk_data(chk_data), .chk_parity(chk_parity),
        .chk_fault_detc_en(chk_fault_detc_en), .chk_data_out(chk_data_out),
        .chk_ecc_fault(chk_ecc_fault), .chk_sbit_err(chk_sbit_err), .chk_dbit_err(chk_dbit_err),
        .enc_data(enc_data), .enc_parity(enc_parity), .busy(busy), .pass_done(pass_done),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
        .dbit_addr(dbit_addr), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] gdat(input logic [AW-1:0] a);
        return 20'h5A5A5 ^ ({15'd0, a} * 20'd40503);
    endfunction

    function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
        return d[5:0] ^ d[11:6] ^ d[17:12] ^ {4'b0, d[19:18]};
    endfunction

    // RAM model: read data registered one cycle after the strobe; injection port for faults.
    logic [DW+PW-1:0] mem [DEPTH];
    logic [DW+PW-1:0] rd_q = '0;
    logic [AW-1:0]    rd_q_addr = '0;
    logic             inj_en = 1'b0;
    logic [AW-1:0]    inj_addr = '0;
    logic [DW+PW-1:0] inj_data = '0;
    logic             fault_inj [DEPTH] = '{default: 1'b0};
    int               cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= {enc(gdat(AW'(a))), gdat(AW'(a))};
        end else begin
            if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
            if (inj_en) mem[inj_addr] <= inj_data;
        end
        if (ram_rd_en) begin
            rd_q      <= mem[ram_rd_addr];
            rd_q_addr <= ram_rd_addr;
        end
    end

    assign ram_rd_data = rd_q;

    // Checker model: errors classified by distance from the known-good word at that address.
    logic [DW-1:0] syn;
    assign syn           = chk_data ^ gdat(rd_q_addr);
    assign chk_ecc_fault = fault_inj[rd_q_addr];
    assign chk_sbit_err  = ($countones(syn) == 1);
    assign chk_dbit_err  = ($countones(syn) >= 2);
    assign chk_data_out  = gdat(rd_q_addr);
    assign enc_parity    = enc(enc_data);

    logic [AW+DW+PW-1:0] wr_q [$];
    logic [AW-1:0]       err_q [$];

    logic prev_rd = 1'b0, prev_wr = 1'b0, prev_pd = 1'b0, prev_err = 1'b0, rd_en_d = 1'b0;
    int   rd_total = 0;
    int   rd7_cnt = 0;

    always @(negedge clk) begin
        if (ram_rd_en) begin
            rd_total <= rd_total + 1;
            if (ram_rd_addr == 5'd7) rd7_cnt <= rd7_cnt + 1;
            check_val("rd_pulse", 32'(prev_rd), 32'd0);
        end
        if (rd_en_d) begin
            check_val("chk_data", 32'(chk_data), 32'(rd_q[DW-1:0]));
            check_val("chk_parity", 32'(chk_parity), 32'(rd_q[DW+PW-1:DW]));
        end
        if (ram_wr_en) begin
            check_val("wr_pulse", 32'(prev_wr), 32'd0);
            if (wr_q.size() == 0) begin
                check_val("wr_unexpected", 32'd1, 32'd0);
            end else begin
                check_val("wr_addr", 32'(ram_wr_addr), 32'(wr_q[0][AW+DW+PW-1:DW+PW]));
                check_val("wr_data", 32'(ram_wr_data), 32'(wr_q[0][DW+PW-1:0]));
                void'(wr_q.pop_front());
            end
        end
        if (err_pulse) begin
            check_val("err_once", 32'(prev_err), 32'd0);
            if (err_q.size() == 0) begin
                check_val("err_unexpected", 32'd1, 32'd0);
            end else begin
                check_val("err_addr", 32'(rd_q_addr), 32'(err_q[0]));
                void'(err_q.pop_front());
            end
        end
        if (pass_done) check_val("pass_pulse", 32'(prev_pd), 32'd0);
        prev_rd  <= ram_rd_en;
        prev_wr  <= ram_wr_en;
        prev_pd  <= pass_done;
        prev_err <= err_pulse;
        rd_en_d  <= ram_rd_en;
    end

    task automatic wait_pass(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pass_done && n < 1000);
        if (!pass_done) check_val("pass_timeout", 32'd0, 32'd1);
        t = cyc;
    endtask

    task automatic wait_rd(input bit any, input logic [AW-1:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ram_rd_en && (any || ram_rd_addr == a)) && n < 1000);
        if (!ram_rd_en) check_val("rd_timeout", 32'd0, 32'd1);
    endtask

    task automatic inject(input logic [AW-1:0] a, input logic [DW+PW-1:0] d);
        inj_addr = a;
        inj_data = d;
        inj_en   = 1'b1;
        @(negedge clk);
        inj_en   = 1'b0;
    endtask

    task automatic inject_sbit(input logic [AW-1:0] a, input int bitn);
        logic [DW-1:0] g;
        g = gdat(a);
        inject(a, {enc(g), g ^ (20'd1 << bitn)});
        wr_q.push_back({a, enc(g), g});
    endtask

    initial begin
        int t0, t1, t2, r0, n0, tot;
        logic [DW-1:0] g;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_rd_en", 32'(ram_rd_en), 32'd0);
        check_val("rst_sbit", 32'(sbit_cnt), 32'd0);
        check_val("rst_dbit_addr", 32'(dbit_addr), 32'd0);
        check_val("rst_fdet", 32'(chk_fault_detc_en), 32'd1);

        // Clean RAM, interval 0: a word every 3 cycles, 96 per pass.
        scrub_en = 1'b1;
        wait_pass(t0);
        wait_pass(t1);
        wait_pass(t2);
        check_val("pass_period0", 32'(t1 - t0), 32'd96);
        check_val("pass_period1", 32'(t2 - t1), 32'd96);
        check_val("clean_cnts", {8'd0, sbit_cnt, dbit_cnt, fault_cnt}, 32'd0);

        // Single-bit error at address 5, then a clean pass.
        inject_sbit(5'd5, 3);
        wait_pass(t0);
        check_val("sbit5_wq", 32'(wr_q.size()), 32'd0);
        check_val("sbit5_cnt", 32'(sbit_cnt), 32'd1);
        wait_pass(t0);
        check_val("sbit5_again", 32'(sbit_cnt), 32'd1);

        // Double-bit at 12 and forced checker fault at 3.
        g = gdat(5'd12);
        fault_inj[3] = 1'b1;
        inject(5'd12, {enc(g), g ^ 20'h00003});
        err_q.push_back(5'd3);
        err_q.push_back(5'd12);
        wait_pass(t0);
        fault_inj[3] = 1'b0;
        inject(5'd12, {enc(g), g});
        check_val("dbit_cnt", 32'(dbit_cnt), 32'd1);
        check_val("dbit_addr", 32'(dbit_addr), 32'd12);
        check_val("fault_cnt", 32'(fault_cnt), 32'd1);
        check_val("err_q", 32'(err_q.size()), 32'd0);
        check_val("nowr_sbit", 32'(sbit_cnt), 32'd1);

        // Sbit at 7 with the functional port stepping in right after the read.
        wait_pass(t0);
        inject_sbit(5'd7, 11);
        r0 = rd7_cnt;
        wait_rd(1'b0, 5'd7);
        @(posedge clk); #1 fifo_busy = 1'b1;
        @(posedge clk); #1 fifo_busy = 1'b0;
        wait_pass(t0);
        check_val("reread7", 32'(rd7_cnt - r0), 32'd2);
        check_val("sbit7_wq", 32'(wr_q.size()), 32'd0);
        check_val("sbit7_cnt", 32'(sbit_cnt), 32'd2);

        // Long functional hold while the scrubber waits in RD.
        wait_rd(1'b1, '0);
        @(posedge clk); #1 fifo_busy = 1'b1;
        n0 = rd_total;
        repeat (50) @(posedge clk);
        #1;
        check_val("hold_no_rd", 32'(rd_total - n0), 32'd0);
        fifo_busy = 1'b0;
        @(negedge clk);
        check_val("rd_on_release", 32'(ram_rd_en), 32'd1);

        // 300 corrected words drive sbit_cnt to saturation.
        tot = 0;
        for (int r = 0; r < 10; r++) begin
            wait_pass(t0);
            for (int a = 0; a < DEPTH; a++) begin
                if (tot < 300) begin
                    inject_sbit(AW'(a), a % DW);
                    tot++;
                end
            end
        end
        wait_pass(t0);
        check_val("sat_wq", 32'(wr_q.size()), 32'd0);
        check_val("sbit_sat", 32'(sbit_cnt), 32'd255);
        check_val("dbit_keep", 32'(dbit_cnt), 32'd1);

        // Drop scrub_en during the inter-word wait.
        scrub_interval = 16'd20;
        wait_rd(1'b1, '0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        scrub_en = 1'b0;
        @(negedge clk);
        check_val("stop_busy", 32'(busy), 32'd0);
        scrub_interval = 16'd0;
        scrub_en = 1'b1;
        wait_rd(1'b1, '0);
        check_val("restart_addr", 32'(ram_rd_addr), 32'd0);

        // Reset landing in WB must drop the write-back.
        inject(5'd9, {enc(gdat(5'd9)), gdat(5'd9) ^ 20'h00100});
        wait_rd(1'b0, 5'd9);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1; scrub_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_val("wbrst_busy", 32'(busy), 32'd0);
        check_val("wbrst_cnts", {8'd0, sbit_cnt, dbit_cnt, fault_cnt}, 32'd0);
        check_val("wbrst_dbit_addr", 32'(dbit_addr), 32'd0);
        check_val("wbrst_enc", 32'(enc_data), 32'd0);
        check_val("wbrst_strobes", {28'd0, ram_rd_en, ram_wr_en, pass_done, err_pulse}, 32'd0);
        check_val("wbrst_addr", 32'(ram_rd_addr), 32'd0);
        check_val("wbrst_fdet", 32'(chk_fault_detc_en), 32'd1);
        check_val("final_wq", 32'(wr_q.size()), 32'd0);
        check_val("final_eq", 32'(err_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
